// File: rtl/mult_accum_if.sv
// Product stream in, accumulated result out: valid/ready on both sides.
// The accumulator is the slave of the product stream and the master of the result stream.
interface mult_accum_if #(
  parameter int N     = 4,
  parameter int ACC_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mult_accum.sv
// Sums LEN consecutive unsigned products into one result presented on a
// registered valid/ready port; accumulation of the next result overlaps a stalled output.
module mult_accum #(
  parameter int N     = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = 11
) (
  input logic        clk,
  input logic        rst_n,
  input logic        clr,
  mult_accum_if.slave bus
);
  localparam int            CW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf_acc;
  logic [ACC_W-1:0] acc_out_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             final_cnt;
  logic             out_take;
  logic             in_ready_c;
  logic             beat;

  // Extra top bit of the sum captures the wrap out of the accumulator width.
  always_comb begin
    sum   = {1'b0, acc} + {{(ACC_W + 1 - 2*N){1'b0}}, bus.prod};
    carry = sum[ACC_W];
  end

  assign final_cnt  = (cnt == LAST);
  assign out_take   = out_valid_q && bus.out_ready;
  // Only the final beat needs a free output register; a consumption on the
  // same edge frees it, so out_ready is allowed to release the stall directly.
  assign in_ready_c = !clr && !(final_cnt && out_valid_q && !bus.out_ready);
  assign beat       = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      ovf_acc     <= 1'b0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_take)
        out_valid_q <= 1'b0;

      if (clr) begin
        acc     <= '0;
        cnt     <= '0;
        ovf_acc <= 1'b0;
      end else if (beat) begin
        if (final_cnt) begin
          acc_out_q   <= sum[ACC_W-1:0];
          ovf_q       <= ovf_acc | carry;
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          ovf_acc     <= 1'b0;
        end else begin
          acc     <= sum[ACC_W-1:0];
          cnt     <= cnt + 1'b1;
          ovf_acc <= ovf_acc | carry;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;
endmodule
